// File: rtl/song_reader.sv
// Song ROM walker feeding note_player: fetches {note, duration} entries, issues one load pulse per note,
// and pulses song_done at the end of the song. Define SONG_READER_LOOP_EN to repeat the song instead of stopping.
module song_reader #(
  parameter int SONG_BITS  = 2,
  parameter int INDEX_BITS = 5,
  parameter int NOTE_BITS  = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            play,
  input  logic [SONG_BITS-1:0]            song,
  input  logic                            note_done,
  input  logic [2*NOTE_BITS-1:0]          rom_dout,
  output logic [SONG_BITS+INDEX_BITS-1:0] rom_addr,
  output logic [NOTE_BITS-1:0]            note_to_load,
  output logic [NOTE_BITS-1:0]            duration_to_load,
  output logic                            load_new_note,
  output logic                            song_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT,
    DONE
  } state_t;

  localparam logic [INDEX_BITS-1:0] LAST_INDEX = '1;

  state_t                  state, state_nxt;
  logic [INDEX_BITS-1:0]   index, index_nxt;
  logic [SONG_BITS-1:0]    song_reg, song_reg_nxt;
  logic [NOTE_BITS-1:0]    note_nxt, duration_nxt;
  logic                    load_nxt, done_nxt;
  logic [NOTE_BITS-1:0]    entry_note, entry_duration;

  assign entry_note     = rom_dout[2*NOTE_BITS-1:NOTE_BITS];
  assign entry_duration = rom_dout[NOTE_BITS-1:0];
  assign rom_addr       = {song_reg, index};

  always_comb begin
    state_nxt    = state;
    index_nxt    = index;
    song_reg_nxt = song_reg;
    note_nxt     = note_to_load;
    duration_nxt = duration_to_load;
    load_nxt     = 1'b0;
    done_nxt     = 1'b0;

    // A song change restarts from the top and outranks every other event
    if (song != song_reg) begin
      song_reg_nxt = song;
      index_nxt    = '0;
      state_nxt    = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (play) state_nxt = FETCH;
        end
        FETCH: begin
          state_nxt = LOAD;
        end
        LOAD: begin
          if (entry_duration == '0) begin
            done_nxt = 1'b1;
`ifdef SONG_READER_LOOP_EN
            index_nxt = '0;
            state_nxt = FETCH;
`else
            state_nxt = DONE;
`endif
          end else begin
            note_nxt     = entry_note;
            duration_nxt = entry_duration;
            load_nxt     = 1'b1;
            state_nxt    = WAIT;
          end
        end
        WAIT: begin
          // Pause keeps the index so the interrupted note is replayed on resume
          if (!play) begin
            state_nxt = IDLE;
          end else if (note_done && !load_new_note) begin
            if (index == LAST_INDEX) begin
              done_nxt = 1'b1;
`ifdef SONG_READER_LOOP_EN
              index_nxt = '0;
              state_nxt = FETCH;
`else
              state_nxt = DONE;
`endif
            end else begin
              index_nxt = index + INDEX_BITS'(1);
              state_nxt = FETCH;
            end
          end
        end
        DONE: begin
          if (!play) begin
            index_nxt = '0;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      index            <= '0;
      song_reg         <= song;
      note_to_load     <= '0;
      duration_to_load <= '0;
      load_new_note    <= 1'b0;
      song_done        <= 1'b0;
    end else begin
      state            <= state_nxt;
      index            <= index_nxt;
      song_reg         <= song_reg_nxt;
      note_to_load     <= note_nxt;
      duration_to_load <= duration_nxt;
      load_new_note    <= load_nxt;
      song_done        <= done_nxt;
    end
  end

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
- Feeds notes into the note player: the upstream end of its note_to_load / duration_to_load / load_new_note / note_done handshake.
- Walks a song ROM with a 1-cycle read latency. Each entry is {note[5:0], duration[5:0]}. The ROM address is {song[1:0], note_index[4:0]}.
- Issues one note per load_new_note pulse, waits for note_done, then fetches the next entry.
- Pulses song_done at end of song. Sits between the top-level play/song controls and note_player.

Parameters:
- SONG_BITS, 2, width of song select (4 songs).
- INDEX_BITS, 5, width of note index (32 entries per song).
- NOTE_BITS, 6, width of note code and of duration field.

Ports:
- clk  input  1  system clock (sys_clk)
- reset  input  1  synchronous, active-high reset
- play  input  1  level; 1 = play/resume, 0 = pause
- song  input  SONG_BITS  song select; sampled every cycle
- note_done  input  1  one-cycle pulse from note_player when the current note's duration has expired
- rom_dout  input  2*NOTE_BITS  song ROM data, {note, duration}; valid 1 cycle after rom_addr
- rom_addr  output  SONG_BITS+INDEX_BITS  {song_reg, index}
- note_to_load  output  NOTE_BITS  registered note code
- duration_to_load  output  NOTE_BITS  registered duration in beats
- load_new_note  output  1  registered one-cycle load pulse
- song_done  output  1  registered one-cycle end-of-song pulse

Behaviour:
- Reset (synchronous, clk edge with reset=1) sets the following, and overrides every other event:
  - state=IDLE, index=0, song_reg=song.
  - note_to_load=0, duration_to_load=0, load_new_note=0, song_done=0, rom_addr={song,0}.
- States are IDLE, FETCH, LOAD, WAIT, DONE. Outputs are registered. rom_addr is driven combinationally from registers.
- IDLE:
  - play=1 → FETCH.
  - Otherwise hold.
  - index is preserved, so IDLE doubles as pause.
- FETCH: rom_addr is presented; unconditionally → LOAD.
- LOAD (rom_dout valid):
  - If duration field == 0 (end marker): song_done=1 for one cycle, → DONE. load_new_note is not asserted.
  - Else: register note_to_load and duration_to_load, load_new_note=1 for one cycle, → WAIT.
- Latency: with play sampled high at edge E0 in IDLE, load_new_note is high in the cycle after E2 (3 edges).
- WAIT:
  - play=0 → IDLE with index unchanged. note_player clears its note on pause, so resuming re-fetches and reissues the same note.
  - note_done=1 while load_new_note=1 is ignored.
  - note_done=1 and index == 31 → song_done pulse, → DONE.
  - note_done=1 otherwise → index+1, → FETCH.
  - If play=0 and note_done=1 in the same cycle, pause wins: the note is replayed on resume.
- DONE:
  - Outputs hold, with load_new_note=0 and song_done=0 after its pulse.
  - play=0 → IDLE with index=0.
- Song change (song != song_reg), in any state:
  - song_reg=song, index=0, state=IDLE, no pulses that cycle.
  - Takes priority over note_done and play.
  - If play is still high, FETCH follows on the next edge.
- FETCH and LOAD ignore play; the fetch completes and pause is honoured in WAIT.
- Index arithmetic is unsigned INDEX_BITS and never wraps silently. Index 31 is always treated as the last entry.

Optional Feature:
- Macro: SONG_READER_LOOP_EN.
- Defined: end of song (end marker or completion at index 31) still pulses song_done, but then sets index=0 and → FETCH instead of DONE. The song repeats while play=1; DONE is unreachable.
- Undefined: behaviour as above; the reader stops in DONE.

Test Plan:
- Reset, then play=1, song=1, ROM[1,0]={note 12, dur 4} → rom_addr=0x20; load_new_note pulses 3 edges after play with note_to_load=12, duration_to_load=4; exactly one pulse.
- Three valid entries then entry 3 duration=0; pulse note_done after each load → indices 0,1,2 loaded in order; song_done pulses once after the third note_done plus 2 cycles; no 4th load_new_note; state DONE.
- play=0 while in WAIT at index 5, then play=1 → entry 5 re-fetched and reloaded (same note/duration); index not advanced.
- Change song from 1 to 2 while in WAIT at index 7, same cycle as note_done → index=0, rom_addr=0x40; the next load_new_note carries ROM[2,0]; no load from song 1 index 8.
- All 32 entries nonzero; pulse note_done 32 times → song_done after the 32nd; with SONG_READER_LOOP_EN, load_new_note for index 0 follows 2 cycles after song_done.
- Assert reset in LOAD → all outputs 0 the next cycle; no load_new_note, state IDLE, index 0.
